// File: rtl/seq_divider_pkg.sv
// Shared definitions for the multicycle signed divider: the divide FSM
// state encodings (also used by the control unit) and the default width.
package seq_divider_pkg;

    localparam int DIV_WIDTH = 32;

    // 3-bit state encodings, kept as plain constants so that legacy
    // control-unit code can compare against the same values.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RUN  = 3'd1;
    localparam logic [2:0] ST_FIX  = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd3;
    localparam logic [2:0] ST_ZERO = 3'd4;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration, purely combinational. The partial
// remainder and quotient shift left together as one register pair; the
// divisor is trial-subtracted on a WIDTH+1-bit value so the comparison
// cannot overflow when the remainder's top bit shifts out.
module seq_divider_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Shift in the next dividend bit, subtract if it fits, record quotient bit.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        shifted = {rem_in, quo_in[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
        rem_out = shifted[WIDTH-1:0];
        quo_out = {quo_in[WIDTH-2:0], 1'b0};
        if (shifted >= {1'b0, divisor}) begin
            // The difference is below the divisor, so it fits in WIDTH bits.
            rem_out    = trial[WIDTH-1:0];
            quo_out[0] = 1'b1;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multicycle signed divider with MIPS DIV semantics. Operands are captured
// as magnitudes on a start pulse, one quotient bit is produced per clock,
// and the signs are reapplied in a final fix-up cycle. HI holds the
// remainder (sign of dividend), LO the quotient (truncated toward zero).
// Divide-by-zero is reported with a one-cycle flag and leaves HI/LO intact.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [2:0]       state_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic             sign_q;
    logic             sign_r;

    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
    always_comb begin
        a_abs = a_in[WIDTH-1] ? -a_in : a_in;
        b_abs = b_in[WIDTH-1] ? -b_in : b_in;
    end

    seq_divider_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (divisor_q),
        .rem_out (rem_step),
        .quo_out (quo_step)
    );

    // Status flags decode straight from the state register.
    always_comb begin
        busy     = (state_q != ST_IDLE);
        done     = (state_q == ST_DONE);
        div_zero = (state_q == ST_ZERO);
    end

    // Divide FSM: capture in IDLE, iterate in RUN, apply signs in FIX.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: the working registers are reset too, so a reset mid-run
        // leaves no stale partial result that a later read could expose.
        if (!reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            hi_out    <= '0;
            lo_out    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        divisor_q <= b_abs;
                        quo_q     <= a_abs;
                        rem_q     <= '0;
                        count_q   <= CNT_W'(WIDTH);
                        sign_q    <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                        sign_r    <= a_in[WIDTH-1];
                        state_q   <= (b_in == '0) ? ST_ZERO : ST_RUN;
                    end
                end
                ST_RUN: begin
                    rem_q   <= rem_step;
                    quo_q   <= quo_step;
                    count_q <= count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    lo_out  <= sign_q ? -quo_q : quo_q;
                    hi_out  <= sign_r ? -rem_q : rem_q;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                ST_ZERO: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: hand-computed quotient/remainder vectors,
// latency and busy-length checks, divide-by-zero, overflow, mid-run reset
// and ignored start pulses. Outputs are sampled on the falling clock edge.
module tb_seq_divider;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int vectors;
    int miscompares;

    int lat;
    int busy_cnt;
    int zero_cnt;
    int extra_done;

    seq_divider #(
        .WIDTH (32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle; returns in the cycle after the accepting edge.
    task automatic do_start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_in  = 32'hDEAD_BEEF;
        b_in  = 32'h0000_0000;
    endtask

    // Called in the cycle after the accepting edge (cycle 1). Returns in the
    // done cycle, or after the cycle budget with lat past the budget.
    task automatic wait_done(output int n, output int nbusy, output int nzero);
        n     = 1;
        nbusy = 0;
        nzero = 0;
        while (n <= 60) begin
            if (busy) nbusy++;
            if (div_zero) nzero++;
            if (done) break;
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        start       = 1'b0;
        a_in        = '0;
        b_in        = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_div_zero", {31'd0, div_zero}, 32'd0);
        chk("rst_hi", hi_out, 32'd0);
        chk("rst_lo", lo_out, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // 100 / 7: latency and busy length
        do_start(32'd100, 32'd7);
        chk("100_7_busy_e0", {31'd0, busy}, 32'd1);
        wait_done(lat, busy_cnt, zero_cnt);
        chk("100_7_latency", lat, 32'd34);
        chk("100_7_busy_cycles", busy_cnt, 32'd34);
        chk("100_7_lo", lo_out, 32'h0000_000E);
        chk("100_7_hi", hi_out, 32'h0000_0002);
        @(negedge clk);
        chk("100_7_done_one_cycle", {31'd0, done}, 32'd0);
        chk("100_7_idle_busy", {31'd0, busy}, 32'd0);

        // -7 / 2
        do_start(32'hFFFF_FFF9, 32'd2);
        wait_done(lat, busy_cnt, zero_cnt);
        chk("m7_2_latency", lat, 32'd34);
        chk("m7_2_lo", lo_out, 32'hFFFF_FFFD);
        chk("m7_2_hi", hi_out, 32'hFFFF_FFFF);

        // 7 / -2
        do_start(32'd7, 32'hFFFF_FFFE);
        wait_done(lat, busy_cnt, zero_cnt);
        chk("7_m2_lo", lo_out, 32'hFFFF_FFFD);
        chk("7_m2_hi", hi_out, 32'h0000_0001);

        // Overflow: most negative / -1 wraps, not flagged
        do_start(32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, busy_cnt, zero_cnt);
        chk("ovf_latency", lat, 32'd34);
        chk("ovf_lo", lo_out, 32'h8000_0000);
        chk("ovf_hi", hi_out, 32'h0000_0000);
        chk("ovf_no_div_zero", zero_cnt, 32'd0);

        // 100 / 7 then 5 / 0: flag only, results untouched
        do_start(32'd100, 32'd7);
        wait_done(lat, busy_cnt, zero_cnt);
        do_start(32'd5, 32'd0);
        chk("dz_flag", {31'd0, div_zero}, 32'd1);
        chk("dz_busy", {31'd0, busy}, 32'd1);
        chk("dz_no_done", {31'd0, done}, 32'd0);
        chk("dz_hi_kept", hi_out, 32'h0000_0002);
        chk("dz_lo_kept", lo_out, 32'h0000_000E);
        @(negedge clk);
        chk("dz_flag_one_cycle", {31'd0, div_zero}, 32'd0);
        chk("dz_idle", {31'd0, busy}, 32'd0);
        extra_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        chk("dz_done_never", extra_done, 32'd0);

        // Reset in the middle of a run
        do_start(32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_hi", hi_out, 32'd0);
        chk("midrst_lo", lo_out, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        extra_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || div_zero || busy) extra_done++;
        end
        chk("midrst_quiet", extra_done, 32'd0);

        // 9 / 3 with stray start pulses during RUN
        do_start(32'd9, 32'd3);
        repeat (4) @(negedge clk);
        a_in  = 32'd100;
        b_in  = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        a_in  = 32'd50;
        b_in  = 32'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, busy_cnt, zero_cnt);
        chk("9_3_lo", lo_out, 32'd3);
        chk("9_3_hi", hi_out, 32'd0);
        chk("9_3_no_div_zero", zero_cnt, 32'd0);

        // start held in the done cycle is ignored
        a_in  = 32'd5;
        b_in  = 32'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_done_busy", {31'd0, busy}, 32'd0);
        chk("start_in_done_dz", {31'd0, div_zero}, 32'd0);
        extra_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        chk("single_done", extra_done, 32'd0);
        chk("final_lo_held", lo_out, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
